hsv_core_issue_hazard: RTL and testbench
========================================

Name: hsv_core_issue_hazard

Overview:
Issue-stage hazard unit between decode and execute. It holds one decoded instruction and checks it against a per-register pending-write scoreboard. It drives the register file read addresses, captures the operands, and hands the instruction downstream over a valid/ready handshake. Writeback traffic passes through it to the register file write port and retires scoreboard entries.

Parameters:
PAYLOAD_W, 64, width of opaque decoded-instruction payload carried alongside operands
PEND_W, 2, width of each per-register pending-write counter

Ports:
clk_core  in  1  core clock
rst_core  in  1  reset; synchronous, active-high
in_valid  in  1  decoded instruction valid
in_ready  out  1  unit can accept an instruction this cycle
in_rs1, in_rs2, in_rd  in  5 each  register indices
in_uses_rs1, in_uses_rs2, in_writes_rd  in  1 each  operand/destination usage flags
in_payload  in  PAYLOAD_W  opaque payload
rs1_addr, rs2_addr  out  5 each  register file read addresses (combinational, from the held instruction)
rs1_data, rs2_data  in  32 each  register file read data (combinational read)
out_valid  out  1  issued instruction valid
out_ready  in  1  execute accepts
out_rs1_value, out_rs2_value  out  32 each  captured operands
out_rd  out  5  destination register index
out_writes_rd  out  1  destination write flag
out_payload  out  PAYLOAD_W  opaque payload
wb_valid, wb_addr(5), wb_data(32)  in  writeback from execute
wr_en, wr_addr(5), wr_data(32)  out  register file write port; combinational pass-through of wb_*
flush  in  1  pipeline flush

Behaviour:
- Stage A holds at most one instruction. The output register holds at most one instruction.
- in_ready = !a_valid || a_issue. Accept occurs when in_valid && in_ready.
- Hazard for rs1: in_uses_rs1 && rs1 != 0 && pend[rs1] != 0. The rs2 hazard is defined the same way.
- Structural stall: writes_rd && rd != 0 && pend[rd] == all-ones.
- a_issue = a_valid && no hazard && no structural stall && (!out_valid || out_ready).
- On a_issue, the output register captures rs1_data/rs2_data (forced to 0 when the operand is unused or its index is 0), rd, writes_rd, and payload. out_valid is set.
- If out_valid && out_ready && !a_issue, out_valid clears.
- Outputs are stable while out_valid && !out_ready.
- Latency: accept at edge E0 gives out_valid at edge E1 at the earliest. Throughput is 1 instruction per cycle.
- Scoreboard:
  - pend[r] increments on a_issue when writes_rd && rd == r && r != 0.
  - pend[r] decrements on wb_valid && wb_addr == r && r != 0.
  - A simultaneous increment and decrement on the same register leaves the count unchanged.
  - pend[0] is always 0.
  - A decrement at 0 is ignored; a debug assertion fires.
- No bypass: a consumer stalled on r issues no earlier than the cycle after the wb for r. The register file holds the value by then.
- wr_en = wb_valid, wr_addr = wb_addr, wr_data = wb_data, always, including during flush and reset.
- Flush (registered effect at the next edge):
  - a_valid and out_valid clear.
  - All pend counters clear; wb in the flush cycle does not underflow.
  - in_ready is 1 in the cycle after the flush.
  - Input presented during the flush cycle is dropped.
- Reset: a_valid=0, out_valid=0, all pend=0, in_ready=1. Output data registers are 0.
- Reset asserted mid-operation takes priority over flush, issue, and wb scoreboard updates.

Test Plan:
- Reset: hold rst_core 2 cycles -> out_valid=0, in_ready=1, wr_en follows wb_valid; pend all 0 (verified by x1..x31 readers issuing with no stall).
- Back-to-back independent: register file preloaded with x1=0x11, x2=0x22; three instructions each reading x1/x2, out_ready=1 -> out_valid on 3 consecutive cycles, each with operands 0x11/0x22.
- RAW stall: issue A (rd=5), then B (rs1=5). B is held with in_ready=0 until wb x5=0xdeadbeef at cycle T -> B out_valid at T+2 (next-edge issue) with out_rs1_value=0xdeadbeef.
- x0 handling: A writes rd=0, then B reads rs1=0 -> no stall; out_rs1_value=0; the scoreboard is never touched.
- Backpressure: out_ready=0 for 3 cycles with 2 instructions queued -> out_* stable, in_ready=0 after stage A fills; after release, both instructions drain in order on consecutive cycles.
- Saturation and flush: PEND_W=2, three issues to rd=7, then a fourth -> the fourth stalls; a wb to x7 lets it issue the next cycle. Then assert flush -> out_valid=0 next cycle, and a reader of x7 issues without stall.

Source files
------------

// File: rtl/hsv_core_issue_hazard.sv
// hsv_core_issue_hazard
//   Issue-stage hazard unit sitting between decode and execute. One decoded
//   instruction is held in stage A. It is checked against a per-register
//   pending-write scoreboard. While it waits, its source indices drive the
//   register file read ports. When it is clear to go, its operands are
//   captured into the output register and handed to execute over a
//   valid/ready handshake. Writeback traffic is passed straight through to the
//   register file write port, and it also retires scoreboard entries.
//
// Ports
//   clk_core, rst_core          clock, synchronous active-high reset
//   in_valid/in_ready           decode handshake; in_rs1/rs2/rd, usage flags,
//                               in_payload describe the offered instruction
//   rs1_addr/rs2_addr           register file read addresses (held instr)
//   rs1_data/rs2_data           register file combinational read data
//   out_valid/out_ready         execute handshake; out_rs1_value,
//                               out_rs2_value, out_rd, out_writes_rd,
//                               out_payload carry the issued instruction
//   wb_valid/wb_addr/wb_data    writeback from execute
//   wr_en/wr_addr/wr_data       register file write port (wb pass-through)
//   flush                       drops both stages and clears the scoreboard
module hsv_core_issue_hazard #(
  parameter int PAYLOAD_W = 64,
  parameter int PEND_W    = 2
) (
  input  logic                 clk_core,
  input  logic                 rst_core,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic                 in_uses_rs1,
  input  logic                 in_uses_rs2,
  input  logic                 in_writes_rd,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  input  logic [31:0]          rs1_data,
  input  logic [31:0]          rs2_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_rs1_value,
  output logic [31:0]          out_rs2_value,
  output logic [4:0]           out_rd,
  output logic                 out_writes_rd,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_addr,
  input  logic [31:0]          wb_data,
  output logic                 wr_en,
  output logic [4:0]           wr_addr,
  output logic [31:0]          wr_data,
  input  logic                 flush
);

  // Stage A: the instruction waiting to issue.
  logic                 a_valid_reg;
  logic [4:0]           a_rs1_reg, a_rs2_reg, a_rd_reg;
  logic                 a_uses_rs1_reg, a_uses_rs2_reg, a_writes_rd_reg;
  logic [PAYLOAD_W-1:0] a_payload_reg;

  // Output register: the instruction offered to execute.
  logic                 out_valid_reg;
  logic [31:0]          out_rs1_reg, out_rs2_reg;
  logic [4:0]           out_rd_reg;
  logic                 out_writes_rd_reg;
  logic [PAYLOAD_W-1:0] out_payload_reg;

  // Scoreboard: number of in-flight writes to each register.
  logic [PEND_W-1:0] pend_reg  [32];
  logic [PEND_W-1:0] pend_next [32];

  logic rs1_hazard, rs2_hazard, pend_full, a_issue, accept;

  assign rs1_hazard = a_uses_rs1_reg && (a_rs1_reg != 5'd0) && (pend_reg[a_rs1_reg] != '0);
  assign rs2_hazard = a_uses_rs2_reg && (a_rs2_reg != 5'd0) && (pend_reg[a_rs2_reg] != '0);
  // A saturated counter cannot record another write, so the writer must wait.
  assign pend_full  = a_writes_rd_reg && (a_rd_reg != 5'd0) && (&pend_reg[a_rd_reg]);

  assign a_issue  = a_valid_reg && !rs1_hazard && !rs2_hazard && !pend_full
                    && (!out_valid_reg || out_ready);
  assign in_ready = !a_valid_reg || a_issue;
  assign accept   = in_valid && in_ready;

  assign rs1_addr = a_rs1_reg;
  assign rs2_addr = a_rs2_reg;

  assign wr_en   = wb_valid;
  assign wr_addr = wb_addr;
  assign wr_data = wb_data;

  assign out_valid     = out_valid_reg;
  assign out_rs1_value = out_rs1_reg;
  assign out_rs2_value = out_rs2_reg;
  assign out_rd        = out_rd_reg;
  assign out_writes_rd = out_writes_rd_reg;
  assign out_payload   = out_payload_reg;

  // Per-register counter update. A retire against an empty counter is
  // ignored, so the same-cycle issue+retire case nets to zero only when the
  // retire is legitimate.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_pend
      logic inc, dec;
      assign inc = (gi != 0) && a_issue && a_writes_rd_reg && (a_rd_reg == 5'(gi));
      assign dec = (gi != 0) && wb_valid && (wb_addr == 5'(gi)) && (pend_reg[gi] != '0);
      assign pend_next[gi] = (inc && !dec) ? pend_reg[gi] + 1'b1 :
                             (!inc && dec) ? pend_reg[gi] - 1'b1 :
                                             pend_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_core) begin
    if (rst_core || flush) begin
      for (int i = 0; i < 32; i++) pend_reg[i] <= '0;
    end else begin
      // Writeback to a register with no outstanding write is a pipeline bug.
      if (wb_valid && (wb_addr != 5'd0))
        assert (pend_reg[wb_addr] != '0);
      for (int i = 0; i < 32; i++) pend_reg[i] <= pend_next[i];
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      a_valid_reg     <= 1'b0;
      a_rs1_reg       <= '0;
      a_rs2_reg       <= '0;
      a_rd_reg        <= '0;
      a_uses_rs1_reg  <= 1'b0;
      a_uses_rs2_reg  <= 1'b0;
      a_writes_rd_reg <= 1'b0;
      a_payload_reg   <= '0;
    end else begin
      if (flush)        a_valid_reg <= 1'b0;
      else if (accept)  a_valid_reg <= 1'b1;
      else if (a_issue) a_valid_reg <= 1'b0;
      if (accept) begin
        a_rs1_reg       <= in_rs1;
        a_rs2_reg       <= in_rs2;
        a_rd_reg        <= in_rd;
        a_uses_rs1_reg  <= in_uses_rs1;
        a_uses_rs2_reg  <= in_uses_rs2;
        a_writes_rd_reg <= in_writes_rd;
        a_payload_reg   <= in_payload;
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      out_valid_reg     <= 1'b0;
      out_rs1_reg       <= '0;
      out_rs2_reg       <= '0;
      out_rd_reg        <= '0;
      out_writes_rd_reg <= 1'b0;
      out_payload_reg   <= '0;
    end else begin
      if (flush)          out_valid_reg <= 1'b0;
      else if (a_issue)   out_valid_reg <= 1'b1;
      else if (out_ready) out_valid_reg <= 1'b0;
      // a_issue implies the slot is free or draining, so the data only
      // changes when the consumer has taken the previous contents.
      if (a_issue && !flush) begin
        out_rs1_reg       <= (a_uses_rs1_reg && a_rs1_reg != 5'd0) ? rs1_data : 32'd0;
        out_rs2_reg       <= (a_uses_rs2_reg && a_rs2_reg != 5'd0) ? rs2_data : 32'd0;
        out_rd_reg        <= a_rd_reg;
        out_writes_rd_reg <= a_writes_rd_reg;
        out_payload_reg   <= a_payload_reg;
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_issue_hazard.sv
module tb_hsv_core_issue_hazard;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_writes_rd;
  logic [63:0] in_payload;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_value, out_rs2_value;
  logic [4:0]  out_rd;
  logic        out_writes_rd;
  logic [63:0] out_payload;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flush;

  int errors = 0;
  int checks = 0;

  always #5 clk_core = ~clk_core;

  hsv_core_issue_hazard #(.PAYLOAD_W(64), .PEND_W(2)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
    .in_payload(in_payload),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value),
    .out_rd(out_rd), .out_writes_rd(out_writes_rd), .out_payload(out_payload),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush)
  );

  // Register file model: initial contents loaded on reset.
  function automatic logic [31:0] init_val(int i);
    if (i == 0) return 32'h0;
    if (i == 1) return 32'h11;
    if (i == 2) return 32'h22;
    return 32'h100 + 32'(i);
  endfunction

  logic [31:0] rf [32];
  always @(posedge clk_core) begin
    if (rst_core) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    end else if (wr_en && wr_addr != 5'd0) begin
      rf[wr_addr] <= wr_data;
    end
  end
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  typedef struct {
    logic [31:0] v, rs1, rs2, rd, u1, u2, w, pl, ordy, wbv, wba, wbd, fl;
    logic [31:0] e_ir, e_ov, e_r1, e_r2, e_rd, e_pl;
  } vec_t;
  vec_t vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                       logic u1, logic u2, logic w, logic [15:0] pl, logic ordy,
                       logic wbv, logic [4:0] wba, logic [31:0] wbd, logic fl);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_uses_rs1 = u1; in_uses_rs2 = u2; in_writes_rd = w;
    in_payload = {48'h0, pl}; out_ready = ordy;
    wb_valid = wbv; wb_addr = wba; wb_data = wbd; flush = fl;
  endtask

  task automatic idle(logic ordy);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, ordy, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_core = 1'b1;
    idle(1'b1);
    wb_valid = 1'b1; // wr_en must follow wb_valid even in reset

    // ---- reset ----
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_core);
      wb_valid = (c == 0);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'h0);
      check("reset_in_ready", 32'(in_ready), 32'h1);
      check("reset_wr_en", 32'(wr_en), 32'(c == 0));
      $display("cycle reset%0d: out_valid=%0d in_ready=%0d wr_en=%0d", c, out_valid, in_ready, wr_en);
    end
    @(negedge clk_core);
    rst_core = 1'b0;
    idle(1'b1);

    // ---- x1..x31 readers: no stall anywhere after reset ----
    for (int k = 0; k < 33; k++) begin
      if (k < 31)
        drive(1'b1, 5'(k + 1), 5'(k + 1), 5'd0, 1'b1, 1'b1, 1'b0, 16'(k + 1), 1'b1,
              1'b0, 5'd0, 32'h0, 1'b0);
      else
        idle(1'b1);
      #1;
      check("reader_in_ready", 32'(in_ready), 32'h1);
      check("reader_out_valid", 32'(out_valid), 32'(k >= 2));
      if (k >= 2) begin
        check("reader_rs1", out_rs1_value, init_val(k - 1));
        check("reader_rs2", out_rs2_value, init_val(k - 1));
      end
      $display("reader %0d: in_ready=%0d out_valid=%0d rs1=%h", k, in_ready, out_valid, out_rs1_value);
      @(negedge clk_core);
    end
    idle(1'b1);
    @(negedge clk_core);

    // ---- directed table ----
    //            v rs1 rs2 rd u1 u2 w  pl   ordy wbv wba wbd          fl  ir ov r1           r2    rd pl
    // back-to-back independent
    vecs.push_back('{1, 1, 2, 0, 1, 1, 0, 'h01, 1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{1, 1, 2, 0, 1, 1, 0, 'h02, 1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{1, 1, 2, 0, 1, 1, 0, 'h03, 1, 0, 0, 0,           0,  1, 1, 'h11,        'h22, 0, 'h01});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 1, 'h11,        'h22, 0, 'h02});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 1, 'h11,        'h22, 0, 'h03});
    // RAW stall on x5
    vecs.push_back('{1, 0, 0, 5, 0, 0, 1, 'h10, 1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{1, 5, 0, 0, 1, 0, 0, 'h11, 1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  0, 1, 0,           0,    5, 'h10});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  0, 0, 0,           0,    0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 1, 5, 'hdeadbeef,  0,  0, 0, 0,           0,    0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 1, 'hdeadbeef,  0,    0, 'h11});
    // x0 handling
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 'h20, 1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{1, 0, 1, 0, 1, 1, 0, 'h21, 1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 1, 0,           0,    0, 'h20});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 1, 0,           'h11, 0, 'h21});
    // backpressure
    vecs.push_back('{1, 1, 0, 0, 1, 0, 0, 'h30, 0, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{1, 0, 2, 0, 0, 1, 0, 'h31, 0, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,           0,  0, 1, 'h11,        0,    0, 'h30});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,           0,  0, 1, 'h11,        0,    0, 'h30});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0,           0,  0, 1, 'h11,        0,    0, 'h30});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 1, 'h11,        0,    0, 'h30});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 1, 0,           'h22, 0, 'h31});
    // saturation on x7
    vecs.push_back('{1, 0, 0, 7, 0, 0, 1, 'h40, 1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{1, 0, 0, 7, 0, 0, 1, 'h41, 1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{1, 0, 0, 7, 0, 0, 1, 'h42, 1, 0, 0, 0,           0,  1, 1, 0,           0,    7, 'h40});
    vecs.push_back('{1, 0, 0, 7, 0, 0, 1, 'h43, 1, 0, 0, 0,           0,  1, 1, 0,           0,    7, 'h41});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  0, 1, 0,           0,    7, 'h42});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 1, 7, 'h77,        0,  0, 0, 0,           0,    0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    // flush: input offered during the flush is dropped
    vecs.push_back('{1, 7, 0, 0, 1, 0, 0, 'h50, 0, 0, 0, 0,           1,  1, 1, 0,           0,    7, 'h43});
    vecs.push_back('{1, 7, 0, 0, 1, 0, 0, 'h51, 0, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 1, 'h77,        0,    0, 'h51});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0,           0,  1, 0, 0,           0,    0, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].v[0], vecs[i].rs1[4:0], vecs[i].rs2[4:0], vecs[i].rd[4:0],
            vecs[i].u1[0], vecs[i].u2[0], vecs[i].w[0], vecs[i].pl[15:0], vecs[i].ordy[0],
            vecs[i].wbv[0], vecs[i].wba[4:0], vecs[i].wbd, vecs[i].fl[0]);
      #1;
      check("vec_in_ready", 32'(in_ready), vecs[i].e_ir);
      check("vec_out_valid", 32'(out_valid), vecs[i].e_ov);
      check("vec_wr_en", 32'(wr_en), vecs[i].wbv);
      if (vecs[i].e_ov[0]) begin
        check("vec_rs1", out_rs1_value, vecs[i].e_r1);
        check("vec_rs2", out_rs2_value, vecs[i].e_r2);
        check("vec_rd", 32'(out_rd), vecs[i].e_rd);
        check("vec_payload", 32'(out_payload[15:0]), vecs[i].e_pl);
      end
      if (vecs[i].wbv[0]) check("vec_wr_data", wr_data, vecs[i].wbd);
      $display("vec %0d: in_ready=%0d out_valid=%0d rs1=%h rs2=%h rd=%0d pl=%h", i,
               in_ready, out_valid, out_rs1_value, out_rs2_value, out_rd, out_payload[15:0]);
      @(negedge clk_core);
    end

    // ---- reset mid-operation wipes the pending write to x9 ----
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 16'h60, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk_core);
    idle(1'b1);
    @(negedge clk_core);
    rst_core = 1'b1;
    #1;
    check("midrst_pre_out_valid", 32'(out_valid), 32'h1);
    $display("midrst pre: out_valid=%0d rd=%0d", out_valid, out_rd);
    @(negedge clk_core);
    rst_core = 1'b0;
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'h61, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    $display("midrst h3: out_valid=%0d in_ready=%0d", out_valid, in_ready);
    @(negedge clk_core);
    idle(1'b1);
    #1;
    check("midrst_no_stall", 32'(in_ready), 32'h1);
    $display("midrst h4: in_ready=%0d", in_ready);
    @(negedge clk_core);
    #1;
    check("midrst_issue_valid", 32'(out_valid), 32'h1);
    check("midrst_issue_rs1", out_rs1_value, init_val(9));
    check("midrst_issue_payload", 32'(out_payload[15:0]), 32'h61);
    $display("midrst h5: out_valid=%0d rs1=%h pl=%h", out_valid, out_rs1_value, out_payload[15:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
